// File: rtl/matrix_fetch_dma_pkg.sv
// matrix_fetch_dma_pkg
//   Shared definitions for the matrix fetch DMA and its reorder buffer:
//   bus widths, default geometry (ELEMS, SLOTS), accelerator opcodes,
//   the controller state enum and a slot-index width helper.
`timescale 1ns/1ps
package matrix_fetch_dma_pkg;

  localparam int PADDR_W    = 40;   // physical address width
  localparam int RES_DATA_W = 64;   // NoC response payload width
  localparam int DATA_W     = 64;   // element width
  localparam int ID_W       = 6;    // transaction id width
  localparam int OP_W       = 6;    // accelerator opcode width

  localparam int DEF_SLOTS  = 8;    // outstanding requests / ROB depth
  localparam int DEF_ELEMS  = 100;  // elements per 10x10 matrix

  localparam logic [OP_W-1:0] OP_FILLA = 6'd0;
  localparam logic [OP_W-1:0] OP_FILLB = 6'd1;
  localparam logic [OP_W-1:0] OP_MULT  = 6'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MULT = 2'd2
  } state_e;

  // Width of a slot index; a single-slot buffer still needs one bit.
  function automatic int idx_w(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/matrix_fetch_rob.sv
// matrix_fetch_rob
//   Reorder buffer for the fetch DMA. Slots are allocated in issue order,
//   filled by responses in any order (addressed by transaction id) and
//   read out strictly in element order.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears bits and data)
//   clr               clear all valid/pending bits (new sequence)
//   alloc_en/idx      mark slot pending when its request is accepted
//   wr_en/id/data     response write; accepted only into a pending,
//                     not-yet-valid slot
//   wr_hit            response was accepted (low on a valid wr_en = drop)
//   rd_idx            slot holding the next element to emit
//   rd_pop            free the read slot (command handshake)
//   rd_valid/rd_data  read slot contents
`timescale 1ns/1ps
module matrix_fetch_rob
  import matrix_fetch_dma_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS,
  parameter int DW    = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       alloc_en,
  input  logic [idx_w(SLOTS)-1:0]    alloc_idx,
  input  logic                       wr_en,
  input  logic [ID_W-1:0]            wr_id,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_hit,
  input  logic [idx_w(SLOTS)-1:0]    rd_idx,
  input  logic                       rd_pop,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data
);

  localparam int IDX_W = idx_w(SLOTS);

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [SLOTS-1:0] pend_q, pend_d;
  logic [DW-1:0]    data_q [SLOTS];
  logic [DW-1:0]    data_d [SLOTS];

  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;

  // Ids beyond the buffer depth can never be pending; compare one bit
  // wider so a 64-deep buffer does not wrap the bound to zero.
  assign wr_in_range = ({1'b0, wr_id} < 7'(SLOTS));
  assign wr_idx      = wr_id[IDX_W-1:0];

  assign rd_valid = valid_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    pend_d  = pend_q;
    data_d  = data_q;
    wr_hit  = wr_en && wr_in_range && pend_q[wr_idx] && !valid_q[wr_idx];
    if (clr) begin
      valid_d = '0;
      pend_d  = '0;
    end else begin
      // Pop, allocate and fill always target different slots: the popped
      // slot is valid (so a fill to it is dropped) and allocation only
      // happens below full occupancy, which never lands on the read slot.
      if (rd_pop) begin
        valid_d[rd_idx] = 1'b0;
        pend_d[rd_idx]  = 1'b0;
      end
      if (alloc_en) begin
        pend_d[alloc_idx] = 1'b1;
      end
      if (wr_hit) begin
        valid_d[wr_idx] = 1'b1;
        data_d[wr_idx]  = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      pend_q  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/matrix_fetch_dma.sv
// matrix_fetch_dma
//   Fetches matrix A then matrix B (ELEMS 64-bit elements each) from memory
//   with up to SLOTS requests in flight, reorders the responses, and feeds
//   the elements to the matrix accelerator as FILLA/FILLB commands in
//   element order, followed by a single MULT command.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start_val/rdy, start_base_a/b start handshake and matrix base addresses
//   mem_req_val/rdy/transid/addr  element read requests
//   mem_resp_val/transid/data     read responses (always accepted)
//   cmd_val/rdy/opcode/config_data accelerator command stream
//   done                          one-cycle pulse after the MULT handshake
//   err                           sticky: an unexpected response arrived
`timescale 1ns/1ps
module matrix_fetch_dma
  import matrix_fetch_dma_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS,
  parameter int ELEMS = DEF_ELEMS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_val,
  output logic                  start_rdy,
  input  logic [PADDR_W-1:0]    start_base_a,
  input  logic [PADDR_W-1:0]    start_base_b,
  input  logic                  mem_req_rdy,
  output logic                  mem_req_val,
  output logic [ID_W-1:0]       mem_req_transid,
  output logic [PADDR_W-1:0]    mem_req_addr,
  input  logic                  mem_resp_val,
  input  logic [ID_W-1:0]       mem_resp_transid,
  input  logic [RES_DATA_W-1:0] mem_resp_data,
  output logic                  cmd_val,
  input  logic                  cmd_rdy,
  output logic [OP_W-1:0]       cmd_opcode,
  output logic [DATA_W-1:0]     cmd_config_data,
  output logic                  done,
  output logic                  err
);

  localparam int TOTAL = 2 * ELEMS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = idx_w(SLOTS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   emit_cnt_q, emit_cnt_d;
  logic [PADDR_W-1:0] base_a_q, base_a_d;
  logic [PADDR_W-1:0] base_b_q, base_b_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   occ;
  logic               start_fire;
  logic               req_fire;
  logic               cmd_fire;
  logic               rob_clr;
  logic               rob_hit;
  logic               rob_valid;
  logic [DATA_W-1:0]  rob_data;
  logic [IDX_W-1:0]   issue_slot;
  logic [IDX_W-1:0]   emit_slot;

  assign issue_slot = issue_cnt_q[IDX_W-1:0];
  assign emit_slot  = emit_cnt_q[IDX_W-1:0];
  assign occ        = issue_cnt_q - emit_cnt_q;

  assign start_rdy  = (state_q == ST_IDLE);
  assign start_fire = start_val && start_rdy;

  assign mem_req_val     = (state_q == ST_RUN) && (int'(issue_cnt_q) < TOTAL)
                           && (int'(occ) < SLOTS);
  assign mem_req_transid = ID_W'(issue_slot);
  assign req_fire        = mem_req_val && mem_req_rdy;

  // Element address: A occupies the first ELEMS issues, B the rest.
  always_comb begin
    if (int'(issue_cnt_q) < ELEMS) begin
      mem_req_addr = base_a_q + (PADDR_W'(issue_cnt_q) << 3);
    end else begin
      mem_req_addr = base_b_q + (PADDR_W'(issue_cnt_q - CNT_W'(ELEMS)) << 3);
    end
  end

  // Command stream straight off the ROB read port, so a response filling the
  // head slot shows up as cmd_val one cycle later.
  always_comb begin
    cmd_val         = 1'b0;
    cmd_opcode      = OP_FILLA;
    cmd_config_data = '0;
    case (state_q)
      ST_RUN: begin
        cmd_val         = rob_valid;
        cmd_opcode      = (int'(emit_cnt_q) < ELEMS) ? OP_FILLA : OP_FILLB;
        cmd_config_data = rob_data;
      end
      ST_MULT: begin
        cmd_val    = 1'b1;
        cmd_opcode = OP_MULT;
      end
      default: ;
    endcase
  end

  assign cmd_fire = cmd_val && cmd_rdy;
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rob_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_val) begin
          state_d     = ST_RUN;
          // Elements are 8-byte aligned; drop any stray low address bits.
          base_a_d    = start_base_a & ~PADDR_W'(7);
          base_b_d    = start_base_b & ~PADDR_W'(7);
          issue_cnt_d = '0;
          emit_cnt_d  = '0;
          err_d       = 1'b0;
          rob_clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (req_fire) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (cmd_fire) begin
          emit_cnt_d = emit_cnt_q + 1'b1;
          if (int'(emit_cnt_q) == TOTAL - 1) begin
            state_d = ST_MULT;
          end
        end
      end
      ST_MULT: begin
        if (cmd_rdy) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Responses seen while idle belong to a sequence cut short by reset;
    // they are dropped silently.
    if ((state_q != ST_IDLE) && mem_resp_val && !rob_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      emit_cnt_q  <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  matrix_fetch_rob #(
    .SLOTS (SLOTS),
    .DW    (DATA_W)
  ) u_rob (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (rob_clr),
    .alloc_en  (req_fire),
    .alloc_idx (issue_slot),
    .wr_en     (mem_resp_val),
    .wr_id     (mem_resp_transid),
    .wr_data   (mem_resp_data[DATA_W-1:0]),
    .wr_hit    (rob_hit),
    .rd_idx    (emit_slot),
    .rd_pop    (cmd_fire && (state_q == ST_RUN)),
    .rd_valid  (rob_valid),
    .rd_data   (rob_data)
  );

endmodule

// File: tb/tb_matrix_fetch_dma.sv
`timescale 1ns/1ps
module tb_matrix_fetch_dma;
  import matrix_fetch_dma_pkg::*;

  localparam int SLOTS = 8;
  localparam int ELEMS = 100;
  localparam int TOTAL = 2 * ELEMS;

  logic                  clk;
  logic                  rst_n;
  logic                  start_val;
  logic                  start_rdy;
  logic [PADDR_W-1:0]    start_base_a;
  logic [PADDR_W-1:0]    start_base_b;
  logic                  mem_req_rdy;
  logic                  mem_req_val;
  logic [ID_W-1:0]       mem_req_transid;
  logic [PADDR_W-1:0]    mem_req_addr;
  logic                  mem_resp_val;
  logic [ID_W-1:0]       mem_resp_transid;
  logic [RES_DATA_W-1:0] mem_resp_data;
  logic                  cmd_val;
  logic                  cmd_rdy;
  logic [OP_W-1:0]       cmd_opcode;
  logic [DATA_W-1:0]     cmd_config_data;
  logic                  done;
  logic                  err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matrix_fetch_dma #(.SLOTS(SLOTS), .ELEMS(ELEMS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_val        (start_val),
    .start_rdy        (start_rdy),
    .start_base_a     (start_base_a),
    .start_base_b     (start_base_b),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_val      (mem_req_val),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .cmd_val          (cmd_val),
    .cmd_rdy          (cmd_rdy),
    .cmd_opcode       (cmd_opcode),
    .cmd_config_data  (cmd_config_data),
    .done             (done),
    .err              (err)
  );

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [PADDR_W-1:0] addr;
  } req_t;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_t               exp_q[$];
  logic [PADDR_W-1:0] addr_q[$];
  req_t               out_q[$];

  int resp_mode    = 0;   // 0: in order, next cycle; 1: reverse per 8-window
  bit hold_resp    = 0;
  bit inject_bad   = 0;
  bit inject_stale = 0;
  bit draining     = 0;
  int n_issued     = 0;
  int n_cmds       = 0;
  int done_cnt     = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [PADDR_W-1:0] a);
    return {24'hC0FFEE, a};
  endfunction

  // Memory model: decides the inputs for the coming rising edge.
  initial begin
    req_t r;
    mem_req_rdy      = 1'b0;
    mem_resp_val     = 1'b0;
    mem_resp_transid = '0;
    mem_resp_data    = '0;
    forever begin
      @(negedge clk);
      mem_resp_val     = 1'b0;
      mem_resp_transid = '0;
      mem_resp_data    = '0;
      if (!rst_n) begin
        out_q.delete();
        draining    = 0;
        mem_req_rdy = 1'b0;
        continue;
      end
      if (inject_stale) begin
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd2;
        mem_resp_data    = 64'hDEAD_0000_0000_0002;
        inject_stale     = 0;
      end else if (inject_bad) begin
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd63;
        mem_resp_data    = 64'hBAD0_BAD0_BAD0_BAD0;
        inject_bad       = 0;
      end else if (!hold_resp && out_q.size() > 0) begin
        if (resp_mode == 0) begin
          r = out_q.pop_front();
          mem_resp_val     = 1'b1;
          mem_resp_transid = r.id;
          mem_resp_data    = data_of(r.addr);
        end else begin
          if (!draining && out_q.size() == SLOTS) draining = 1;
          if (draining) begin
            r = out_q.pop_back();
            mem_resp_val     = 1'b1;
            mem_resp_transid = r.id;
            mem_resp_data    = data_of(r.addr);
            if (out_q.size() == 0) draining = 0;
          end
        end
      end
      mem_req_rdy = 1'b1;
      if (mem_req_val && mem_req_rdy) begin
        n_issued++;
        if (addr_q.size() == 0) begin
          check("req_unexpected", {40'd0, mem_req_addr}, 80'd0);
        end else begin
          check("req_addr", {40'd0, mem_req_addr}, {40'd0, addr_q.pop_front()});
        end
        out_q.push_back({mem_req_transid, mem_req_addr});
      end
    end
  end

  // Command monitor / scoreboard.
  initial begin
    bit        stalled  = 0;
    bit        mult_prv = 0;
    cmd_t      saved;
    cmd_t      e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled  = 0;
        mult_prv = 0;
        continue;
      end
      if (done) done_cnt++;
      if (done || mult_prv) check("done_pulse", {79'd0, done}, {79'd0, mult_prv});
      mult_prv = 0;
      if (stalled) begin
        check("stall_stable", {9'd0, cmd_val, cmd_opcode, cmd_config_data},
              {9'd0, 1'b1, saved.op, saved.data});
      end
      if (cmd_val && cmd_rdy) begin
        n_cmds++;
        if (exp_q.size() == 0) begin
          check("cmd_unexpected", {10'd0, cmd_opcode, cmd_config_data}, 80'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_opcode", {74'd0, cmd_opcode}, {74'd0, e.op});
          check("cmd_data", {16'd0, cmd_config_data}, {16'd0, e.data});
        end
        if (cmd_opcode == OP_MULT) mult_prv = 1;
      end
      stalled = cmd_val && !cmd_rdy;
      saved   = {cmd_opcode, cmd_config_data};
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_rdy"}, {79'd0, start_rdy}, 80'd1);
    check({tag, "_req_val"}, {79'd0, mem_req_val}, 80'd0);
    check({tag, "_req_id"}, {74'd0, mem_req_transid}, 80'd0);
    check({tag, "_req_addr"}, {40'd0, mem_req_addr}, 80'd0);
    check({tag, "_cmd_val"}, {79'd0, cmd_val}, 80'd0);
    check({tag, "_cmd_op"}, {74'd0, cmd_opcode}, 80'd0);
    check({tag, "_cmd_data"}, {16'd0, cmd_config_data}, 80'd0);
    check({tag, "_done"}, {79'd0, done}, 80'd0);
    check({tag, "_err"}, {79'd0, err}, 80'd0);
  endtask

  // Queue expectations for one sequence, then issue the start handshake.
  // exp_a/exp_b are the 8-byte-aligned bases the DUT must use.
  task automatic start_seq(input logic [PADDR_W-1:0] ba, input logic [PADDR_W-1:0] bb,
                           input logic [PADDR_W-1:0] exp_a, input logic [PADDR_W-1:0] exp_b);
    logic [PADDR_W-1:0] a;
    for (int i = 0; i < ELEMS; i++) begin
      a = exp_a + PADDR_W'(8 * i);
      addr_q.push_back(a);
      exp_q.push_back({OP_FILLA, data_of(a)});
    end
    for (int i = 0; i < ELEMS; i++) begin
      a = exp_b + PADDR_W'(8 * i);
      addr_q.push_back(a);
      exp_q.push_back({OP_FILLB, data_of(a)});
    end
    exp_q.push_back({OP_MULT, 64'd0});
    n_cmds   = 0;
    n_issued = 0;
    check("start_rdy_idle", {79'd0, start_rdy}, 80'd1);
    start_base_a = ba;
    start_base_b = bb;
    start_val    = 1'b1;
    @(posedge clk); #1;
    start_val = 1'b0;
    check("start_rdy_busy", {79'd0, start_rdy}, 80'd0);
    check("first_req_val", {79'd0, mem_req_val}, 80'd1);
    check("first_req_addr", {40'd0, mem_req_addr}, {40'd0, exp_a});
    check("first_req_id", {74'd0, mem_req_transid}, 80'd0);
  endtask

  task automatic wait_cmds(input int n, input int budget, input string nm);
    int c = 0;
    while (n_cmds < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check({nm, "_reached"}, {79'd0, (n_cmds >= n)}, 80'd1);
  endtask

  task automatic finish_seq(input string nm, input logic exp_err);
    int d0 = done_cnt;
    int c  = 0;
    while (done_cnt == d0 && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    check({nm, "_done_seen"}, {79'd0, (done_cnt != d0)}, 80'd1);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_one_done"}, 80'(done_cnt - d0), 80'd1);
    check({nm, "_cmd_count"}, 80'(n_cmds), 80'(TOTAL + 1));
    check({nm, "_exp_left"}, 80'(exp_q.size()), 80'd0);
    check({nm, "_addr_left"}, 80'(addr_q.size()), 80'd0);
    check({nm, "_idle"}, {79'd0, start_rdy}, 80'd1);
    check({nm, "_err"}, {79'd0, err}, {79'd0, exp_err});
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    start_val    = 1'b0;
    start_base_a = '0;
    start_base_b = '0;
    cmd_rdy      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_in");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_out");

    // Baseline: in-order memory, accelerator always ready.
    resp_mode = 0;
    start_seq(40'h1000, 40'h2000, 40'h1000, 40'h2000);
    finish_seq("inorder", 1'b0);

    // Reverse order inside each 8-slot window; unaligned base A.
    resp_mode = 1;
    start_seq(40'h4007, 40'h8000, 40'h4000, 40'h8000);
    finish_seq("reverse", 1'b0);

    // Responses withheld: issue must stop at SLOTS outstanding.
    resp_mode = 0;
    hold_resp = 1;
    start_seq(40'h10000, 40'h20000, 40'h10000, 40'h20000);
    repeat (30) @(posedge clk);
    #1;
    check("withheld_issued", 80'(n_issued), 80'(SLOTS));
    check("withheld_req_val", {79'd0, mem_req_val}, 80'd0);
    hold_resp = 0;
    finish_seq("withheld", 1'b0);

    // Accelerator back-pressure mid-stream.
    start_seq(40'h30000, 40'h38000, 40'h30000, 40'h38000);
    wait_cmds(37, 500, "stall_pre");
    cmd_rdy = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("stall_cmd_val", {79'd0, cmd_val}, 80'd1);
    cmd_rdy = 1'b1;
    finish_seq("stall", 1'b0);

    // Unknown transaction id: err sets, stream unaffected.
    start_seq(40'h50000, 40'h58000, 40'h50000, 40'h58000);
    wait_cmds(10, 500, "bad_pre");
    check("bad_err_before", {79'd0, err}, 80'd0);
    inject_bad = 1;
    finish_seq("badid", 1'b1);

    // Reset mid-sequence, stale response, then full fresh run.
    start_seq(40'h1000, 40'h2000, 40'h1000, 40'h2000);
    check("start_clears_err", {79'd0, err}, 80'd0);
    wait_cmds(57, 500, "rst_pre");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    inject_stale = 1;
    repeat (4) @(posedge clk);
    #1;
    check("stale_no_err", {79'd0, err}, 80'd0);
    check("stale_idle", {79'd0, start_rdy}, 80'd1);
    start_seq(40'h1000, 40'h2000, 40'h1000, 40'h2000);
    finish_seq("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
